swu_window_ctrl: RTL and testbench

//  Sequencer for the asymmetric sliding-window buffer RAM in the SWU. Admits wide input pixels

---
 rtl/swu_pkg.sv | 35 +++
 rtl/swu_rd_pipe.sv | 64 ++++++
 rtl/swu_window_ctrl.sv | 158 +++++++++++++++
 tb/tb_swu_window_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/swu_pkg.sv
// Shared helpers for the SWU sliding-window sequencer: width math, output
// frame length and the width used for signed pixel indices.
package swu_pkg;

   // Signed pixel index width; wide enough for o*S-PAD across any practical frame.
   localparam int PIX_IDX_W = 16;

   // Ceiling log2 for elaboration-time width calculations.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

   // Register width able to hold values 0..count-1, never narrower than one bit.
   function automatic int width_of(input int count);
      return (clog2(count) < 1) ? 1 : clog2(count);
   endfunction

   // Number of window positions produced per frame.
   function automatic int calc_ofm_dim(input int ifm_dim, input int k, input int s, input int pad);
      return (ifm_dim + 2 * pad - k) / s + 1;
   endfunction

   // Non-negative residue of -pad modulo depth, i.e. the slot of pixel index -pad.
   function automatic int neg_mod(input int pad, input int depth);
      return (depth - (pad % depth)) % depth;
   endfunction

endpackage

// File: rtl/swu_rd_pipe.sv
// Two-stage read pipeline bookkeeping for the window buffer RAM: stage 1 is
// the RAM read register (enaB), stage 2 the output register doB (enaB_q).
module swu_rd_pipe (
   input  logic clk,
   input  logic rst_n,
   input  logic can_issue,
   input  logic issue_pad,
   input  logic issue_last,
   input  logic out_ready,
   output logic rd_en,
   output logic rd_en_q,
   output logic zeropad,
   output logic out_valid,
   output logic frame_done
);

   logic s1_v;
   logic s1_pad;
   logic s1_last;
   logic s2_v;
   logic s2_last;

   // Advance each stage only when the stage behind it can take the data.
   always_comb begin
      rd_en_q = s1_v && (!s2_v || out_ready);
      rd_en   = can_issue && (!s1_v || rd_en_q);
   end

   assign zeropad    = s1_pad;
   assign out_valid  = s2_v;
   assign frame_done = s2_v && s2_last && out_ready;

   // Stage 1 tracks the chunk sitting in the RAM read register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v    <= 1'b0;
         s1_pad  <= 1'b0;
         s1_last <= 1'b0;
      end else if (rd_en) begin
         s1_v    <= 1'b1;
         s1_pad  <= issue_pad;
         s1_last <= issue_last;
      end else if (rd_en_q) begin
         s1_v    <= 1'b0;
         s1_pad  <= 1'b0;
         s1_last <= 1'b0;
      end
   end

   // Stage 2 tracks the chunk held in doB until downstream takes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_v    <= 1'b0;
         s2_last <= 1'b0;
      end else if (rd_en_q) begin
         s2_v    <= 1'b1;
         s2_last <= s1_last;
      end else if (out_ready) begin
         s2_v    <= 1'b0;
         s2_last <= 1'b0;
      end
   end

endmodule

// File: rtl/swu_window_ctrl.sv
// Sliding-window buffer sequencer: admits wide pixels into a circular buffer
// and issues narrow reads in 1D convolution window order with zero padding.
module swu_window_ctrl
   import swu_pkg::*;
#(
   parameter int IFM_DIM    = 16,
   parameter int K          = 3,
   parameter int S          = 1,
   parameter int PAD        = 1,
   parameter int RATIO      = 4,
   parameter int DEPTH      = 8,
   parameter int ADDRWIDTHA = 3,
   parameter int ADDRWIDTHB = 5
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  wr_en,
   output logic [ADDRWIDTHA-1:0] wr_addr,
   output logic                  rd_en,
   output logic [ADDRWIDTHB-1:0] rd_addr,
   output logic                  rd_en_q,
   output logic                  zeropad,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  frame_done
);

   localparam int OFM_DIM = calc_ofm_dim(IFM_DIM, K, S, PAD);
   localparam int WC_W    = width_of(IFM_DIM + 1);
   localparam int O_W     = width_of(OFM_DIM);
   localparam int K_W     = width_of(K);
   localparam int C_W     = width_of(RATIO);
   localparam int S_SLOT  = S % DEPTH;

   localparam logic [O_W-1:0]        O_LAST     = O_W'(OFM_DIM - 1);
   localparam logic [K_W-1:0]        K_LAST     = K_W'(K - 1);
   localparam logic [C_W-1:0]        C_LAST     = C_W'(RATIO - 1);
   localparam logic [ADDRWIDTHA-1:0] A_LAST     = ADDRWIDTHA'(DEPTH - 1);
   localparam logic [ADDRWIDTHA-1:0] O_PTR_INIT = ADDRWIDTHA'(neg_mod(PAD, DEPTH));
   localparam logic signed [PIX_IDX_W-1:0] O_PIX_INIT = PIX_IDX_W'(-PAD);
   localparam logic signed [PIX_IDX_W-1:0] S_PIX      = PIX_IDX_W'(S);

   logic [WC_W-1:0]       wr_cnt;
   logic [ADDRWIDTHA-1:0] wr_ptr;
   logic [O_W-1:0]        o_idx;
   logic [K_W-1:0]        k_idx;
   logic [C_W-1:0]        c_idx;
   logic signed [PIX_IDX_W-1:0] o_pix;
   logic [ADDRWIDTHA-1:0] o_ptr;
   logic [ADDRWIDTHA-1:0] o_ptr_next;
   logic                  run;
   logic                  can_issue;
   logic                  issue_pad;
   logic                  issue_last;
   int                    o_pix_i;
   int                    p_i;
   int                    wc_i;
   int                    base_i;
   int                    p_slot;
   int                    o_slot;

   // Window bookkeeping: o_pix is the first pixel of the current window and
   // o_ptr its buffer slot, so the read pointer never needs a divider.
   always_comb begin
      o_pix_i    = int'(o_pix);
      p_i        = o_pix_i + int'(k_idx);
      wc_i       = int'(wr_cnt);
      base_i     = (o_pix_i < 0) ? 0 : o_pix_i;
      p_slot     = int'(o_ptr) + int'(k_idx);
      if (p_slot >= DEPTH) begin
         p_slot = p_slot - DEPTH;
      end
      o_slot     = int'(o_ptr) + S_SLOT;
      if (o_slot >= DEPTH) begin
         o_slot = o_slot - DEPTH;
      end
      issue_pad  = (p_i < 0) || (p_i >= IFM_DIM);
      can_issue  = run && (issue_pad || (p_i < wc_i));
      in_ready   = (wc_i < IFM_DIM) && ((wc_i - base_i) < DEPTH);
      issue_last = (o_idx == O_LAST) && (k_idx == K_LAST) && (c_idx == C_LAST);
      rd_addr    = ADDRWIDTHB'(p_slot * RATIO + int'(c_idx));
      o_ptr_next = ADDRWIDTHA'(o_slot);
   end

   assign wr_en   = in_valid && in_ready;
   assign wr_addr = wr_ptr;

   // Hold off reads for the first cycle out of reset so rd_en is low while reset is asserted.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         run <= 1'b0;
      end else begin
         run <= 1'b1;
      end
   end

   // Write counter and wrapping write pointer; both restart once the final chunk has issued.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         wr_cnt <= '0;
         wr_ptr <= '0;
      end else if (rd_en && issue_last) begin
         wr_cnt <= '0;
         wr_ptr <= '0;
      end else if (wr_en) begin
         wr_cnt <= wr_cnt + 1'b1;
         wr_ptr <= (wr_ptr == A_LAST) ? '0 : wr_ptr + 1'b1;
      end
   end

   // Issue counters stepping c fastest, then k, then the window position o.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         o_idx <= '0;
         k_idx <= '0;
         c_idx <= '0;
         o_pix <= O_PIX_INIT;
         o_ptr <= O_PTR_INIT;
      end else if (rd_en) begin
         if (c_idx == C_LAST) begin
            c_idx <= '0;
            if (k_idx == K_LAST) begin
               k_idx <= '0;
               if (o_idx == O_LAST) begin
                  o_idx <= '0;
                  o_pix <= O_PIX_INIT;
                  o_ptr <= O_PTR_INIT;
               end else begin
                  o_idx <= o_idx + 1'b1;
                  o_pix <= o_pix + S_PIX;
                  o_ptr <= o_ptr_next;
               end
            end else begin
               k_idx <= k_idx + 1'b1;
            end
         end else begin
            c_idx <= c_idx + 1'b1;
         end
      end
   end

   swu_rd_pipe u_rd_pipe (
      .clk        (ap_clk),
      .rst_n      (ap_rst_n),
      .can_issue  (can_issue),
      .issue_pad  (issue_pad),
      .issue_last (issue_last),
      .out_ready  (out_ready),
      .rd_en      (rd_en),
      .rd_en_q    (rd_en_q),
      .zeropad    (zeropad),
      .out_valid  (out_valid),
      .frame_done (frame_done)
   );

endmodule

// File: tb/tb_swu_window_ctrl.sv
// Directed bench for swu_window_ctrl: instance a uses the padded K=3 setup,
// instance b the DEPTH=K=3 unpadded setup that exercises in_ready backpressure.
module tb_swu_window_ctrl;

   typedef struct {
      bit exp_pad;
      int exp_addr;
   } vec_t;

   logic clk;
   logic rst_n;

   logic       a_in_valid, a_in_ready, a_wr_en, a_rd_en, a_rd_en_q, a_zeropad;
   logic       a_out_valid, a_out_ready, a_frame_done;
   logic [1:0] a_wr_addr;
   logic [2:0] a_rd_addr;

   logic       b_in_valid, b_in_ready, b_wr_en, b_rd_en, b_rd_en_q, b_zeropad;
   logic       b_out_valid, b_out_ready, b_frame_done;
   logic [1:0] b_wr_addr;
   logic [2:0] b_rd_addr;

   int total;
   int bad;

   vec_t t1_tab [24];
   vec_t b_tab  [36];
   int   t1_addr_src [24] = '{-1, -1, 0, 1, 2, 3,
                              0, 1, 2, 3, 4, 5,
                              2, 3, 4, 5, 6, 7,
                              4, 5, 6, 7, -1, -1};

   int a_got_addr [$];
   bit a_got_pad  [$];
   int a_wr_seen  [$];
   int a_done_cnt, a_viol, a_rb, a_dob;
   bit a_dob_pad, a_overlap;

   int b_got_addr [$];
   bit b_got_pad  [$];
   int b_wr_seen  [$];
   int b_done_cnt, b_rb, b_dob;
   bit b_dob_pad, b_stall3, b_early;

   swu_window_ctrl #(
      .IFM_DIM(4), .K(3), .S(1), .PAD(1), .RATIO(2), .DEPTH(4),
      .ADDRWIDTHA(2), .ADDRWIDTHB(3)
   ) dut_a (
      .ap_clk(clk), .ap_rst_n(rst_n),
      .in_valid(a_in_valid), .in_ready(a_in_ready),
      .wr_en(a_wr_en), .wr_addr(a_wr_addr),
      .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_en_q(a_rd_en_q),
      .zeropad(a_zeropad), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .frame_done(a_frame_done)
   );

   swu_window_ctrl #(
      .IFM_DIM(8), .K(3), .S(1), .PAD(0), .RATIO(2), .DEPTH(3),
      .ADDRWIDTHA(2), .ADDRWIDTHB(3)
   ) dut_b (
      .ap_clk(clk), .ap_rst_n(rst_n),
      .in_valid(b_in_valid), .in_ready(b_in_ready),
      .wr_en(b_wr_en), .wr_addr(b_wr_addr),
      .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_en_q(b_rd_en_q),
      .zeropad(b_zeropad), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .frame_done(b_frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model of the RAM read/output registers for instance a, plus handshake logging.
   always @(negedge clk) begin
      if (!rst_n) begin
         a_got_addr.delete();
         a_got_pad.delete();
         a_wr_seen.delete();
         a_done_cnt <= 0;
         a_viol     <= 0;
         a_overlap  <= 1'b0;
         a_rb       <= 0;
         a_dob      <= 0;
         a_dob_pad  <= 1'b0;
      end else begin
         if (a_out_valid && a_out_ready) begin
            a_got_addr.push_back(a_dob);
            a_got_pad.push_back(a_dob_pad);
         end
         if (a_frame_done) a_done_cnt <= a_done_cnt + 1;
         if (a_out_valid && !a_out_ready && a_rd_en_q) a_viol <= a_viol + 1;
         if (a_wr_en) begin
            if (a_done_cnt == 0 && a_wr_seen.size() >= 4) a_overlap <= 1'b1;
            a_wr_seen.push_back(int'(a_wr_addr));
         end
         if (a_rd_en_q) begin
            a_dob     <= a_rb;
            a_dob_pad <= a_zeropad;
         end
         if (a_rd_en) a_rb <= int'(a_rd_addr);
      end
   end

   // Same register model for instance b, plus tracking of when in_ready drops.
   always @(negedge clk) begin
      if (!rst_n) begin
         b_got_addr.delete();
         b_got_pad.delete();
         b_wr_seen.delete();
         b_done_cnt <= 0;
         b_stall3   <= 1'b0;
         b_early    <= 1'b0;
         b_rb       <= 0;
         b_dob      <= 0;
         b_dob_pad  <= 1'b0;
      end else begin
         if (b_out_valid && b_out_ready) begin
            b_got_addr.push_back(b_dob);
            b_got_pad.push_back(b_dob_pad);
         end
         if (b_frame_done) b_done_cnt <= b_done_cnt + 1;
         if (b_in_valid && !b_in_ready && b_wr_seen.size() == 3) b_stall3 <= 1'b1;
         if (b_in_valid && !b_in_ready && b_wr_seen.size() < 3) b_early <= 1'b1;
         if (b_wr_en) b_wr_seen.push_back(int'(b_wr_addr));
         if (b_rd_en_q) begin
            b_dob     <= b_rb;
            b_dob_pad <= b_zeropad;
         end
         if (b_rd_en) b_rb <= int'(b_rd_addr);
      end
   end

   task automatic check_output(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("[TB] FAIL %s: got=%0d expected=%0d", name, got, want);
      end
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      a_in_valid  = 1'b0;
      a_out_ready = 1'b1;
      b_in_valid  = 1'b0;
      b_out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   // Streams npix pixels into one instance until want_done frames finish or the budget runs out.
   task automatic apply_stimulus(input bit sel_b, input int npix, input bit toggle,
                                 input int want_done, input int max_cycles);
      int  left;
      bit  fire;
      bit  rdy;
      int  done;
      left = npix;
      rdy  = 1'b1;
      if (sel_b) begin b_in_valid = (left > 0); b_out_ready = rdy; end
      else       begin a_in_valid = (left > 0); a_out_ready = rdy; end
      for (int cyc = 0; cyc < max_cycles; cyc++) begin
         @(negedge clk);
         fire = sel_b ? (b_in_valid && b_in_ready) : (a_in_valid && a_in_ready);
         @(posedge clk);
         #1;
         if (fire) left--;
         done = sel_b ? b_done_cnt : a_done_cnt;
         if (done >= want_done) break;
         if (toggle) rdy = ~rdy;
         if (sel_b) begin b_in_valid = (left > 0); b_out_ready = rdy; end
         else       begin a_in_valid = (left > 0); a_out_ready = rdy; end
      end
      a_in_valid = 1'b0;
      b_in_valid = 1'b0;
      check_output(sel_b ? "b_frame_done_count" : "a_frame_done_count",
                   sel_b ? b_done_cnt : a_done_cnt, want_done);
   endtask

   task automatic compare_a(input string tag, input int reps);
      int n;
      n = 24 * reps;
      check_output({tag, "_chunk_count"}, a_got_addr.size(), n);
      for (int i = 0; i < n && i < a_got_addr.size(); i++) begin
         check_output($sformatf("%s_pad[%0d]", tag, i), int'(a_got_pad[i]), int'(t1_tab[i % 24].exp_pad));
         if (!t1_tab[i % 24].exp_pad)
            check_output($sformatf("%s_addr[%0d]", tag, i), a_got_addr[i], t1_tab[i % 24].exp_addr);
      end
      check_output({tag, "_write_count"}, a_wr_seen.size(), 4 * reps);
      for (int i = 0; i < a_wr_seen.size() && i < 4 * reps; i++)
         check_output($sformatf("%s_wr_addr[%0d]", tag, i), a_wr_seen[i], i % 4);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      for (int i = 0; i < 24; i++) begin
         t1_tab[i].exp_pad  = (t1_addr_src[i] < 0);
         t1_tab[i].exp_addr = t1_addr_src[i];
      end
      for (int o = 0; o < 6; o++)
         for (int k = 0; k < 3; k++)
            for (int c = 0; c < 2; c++) begin
               b_tab[o * 6 + k * 2 + c].exp_pad  = 1'b0;
               b_tab[o * 6 + k * 2 + c].exp_addr = ((o + k) % 3) * 2 + c;
            end

      // Reset values while reset is held.
      rst_n       = 1'b0;
      a_in_valid  = 1'b0;
      a_out_ready = 1'b1;
      b_in_valid  = 1'b0;
      b_out_ready = 1'b1;
      #12;
      check_output("rst_in_ready", int'(a_in_ready), 1);
      check_output("rst_out_valid", int'(a_out_valid), 0);
      check_output("rst_rd_en", int'(a_rd_en), 0);
      check_output("rst_rd_en_q", int'(a_rd_en_q), 0);
      check_output("rst_frame_done", int'(a_frame_done), 0);
      check_output("rst_zeropad", int'(a_zeropad), 0);

      // Single frame, back-to-back pixels, output always ready.
      do_reset();
      apply_stimulus(1'b0, 4, 1'b0, 1, 300);
      compare_a("t1", 1);

      // No input: only the two leading pad chunks can come out.
      do_reset();
      repeat (20) @(posedge clk);
      #1;
      check_output("t2_stall_count", a_got_addr.size(), 2);
      check_output("t2_stall_out_valid", int'(a_out_valid), 0);
      check_output("t2_stall_rd_en", int'(a_rd_en), 0);
      apply_stimulus(1'b0, 4, 1'b0, 1, 300);
      compare_a("t2", 1);

      // Output ready toggling every cycle.
      do_reset();
      apply_stimulus(1'b0, 4, 1'b1, 1, 400);
      compare_a("t3", 1);
      check_output("t3_load_while_held", a_viol, 0);

      // Two frames back to back; frame-2 writes must begin before frame 1 drains.
      do_reset();
      apply_stimulus(1'b0, 8, 1'b0, 2, 400);
      compare_a("t5", 2);
      check_output("t5_overlap", int'(a_overlap), 1);

      // Buffer just as deep as the kernel: in_ready must stall at three pixels.
      do_reset();
      apply_stimulus(1'b1, 8, 1'b0, 1, 400);
      check_output("t4_chunk_count", b_got_addr.size(), 36);
      for (int i = 0; i < 36 && i < b_got_addr.size(); i++) begin
         check_output($sformatf("t4_pad[%0d]", i), int'(b_got_pad[i]), int'(b_tab[i].exp_pad));
         check_output($sformatf("t4_addr[%0d]", i), b_got_addr[i], b_tab[i].exp_addr);
      end
      check_output("t4_write_count", b_wr_seen.size(), 8);
      for (int i = 0; i < 8 && i < b_wr_seen.size(); i++)
         check_output($sformatf("t4_wr_addr[%0d]", i), b_wr_seen[i], i % 3);
      check_output("t4_stall_at_3", int'(b_stall3), 1);
      check_output("t4_early_stall", int'(b_early), 0);

      // Asynchronous reset between edges in the middle of a frame.
      do_reset();
      a_out_ready = 1'b1;
      a_in_valid  = 1'b1;
      repeat (6) @(posedge clk);
      #3;
      rst_n      = 1'b0;
      a_in_valid = 1'b0;
      #1;
      check_output("t6_in_ready", int'(a_in_ready), 1);
      check_output("t6_out_valid", int'(a_out_valid), 0);
      check_output("t6_rd_en", int'(a_rd_en), 0);
      check_output("t6_rd_en_q", int'(a_rd_en_q), 0);
      check_output("t6_zeropad", int'(a_zeropad), 0);
      check_output("t6_frame_done", int'(a_frame_done), 0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      apply_stimulus(1'b0, 4, 1'b0, 1, 300);
      compare_a("t6", 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
